// File: rtl/d_flip_flop_cell.sv
// WIDTH-bit bank of D flip-flops with a shared load enable and an asynchronous,
// active-high reset to RESET_VALUE. Qn is the bitwise complement of Q.
module d_flip_flop_cell #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  // Reset is in the sensitivity list, so it acts at once and also wins over
  // a coincident clock edge. Q has no power-up value; it stays unknown until
  // the first reset or load.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples D
  // before any of them updates, matching real hardware on a shared edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Q <= RESET_VALUE;
    end else if (En) begin
      Q <= D;
    end
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_d_flip_flop_cell.sv
// Directed bench for d_flip_flop_cell: a 64-bit instance with zero reset value
// and an 8-bit instance with a non-zero reset value, sharing clock and reset.
`timescale 1ns/1ps
module tb_d_flip_flop_cell;

  localparam logic [63:0] ONES64 = '1;
  localparam logic [63:0] A5     = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] PAT1   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PAT2   = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [7:0]  RV8    = 8'h5A;

  logic        clk = 1'b0;
  logic        reset;
  logic        en64, en8;
  logic [63:0] d64, q64, qn64;
  logic [7:0]  d8, q8, qn8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  d_flip_flop_cell #(.WIDTH(64)) dut64 (
    .Clk(clk), .Reset(reset), .En(en64), .D(d64), .Q(q64), .Qn(qn64)
  );

  d_flip_flop_cell #(.WIDTH(8), .RESET_VALUE(RV8)) dut8 (
    .Clk(clk), .Reset(reset), .En(en8), .D(d8), .Q(q8), .Qn(qn8)
  );

  task automatic wait_until(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  // Q must never pick up D while nothing has loaded it (unknown in a 4-state
  // simulator, never the all-ones D value in any simulator).
  task automatic test_no_load();
    reset = 1'b0; en64 = 1'b0; en8 = 1'b0; d64 = ONES64; d8 = 8'hFF;
    for (int t = 9; t < 100; t += 10) begin
      wait_until(t);
      checks++;
      if (q64 === ONES64) begin
        failures++;
        $display("FAIL no_load t=%0t q=%h must not equal d=%h", $realtime, q64, d64);
      end
    end
  endtask

  task automatic test_reset();
    wait_until(100);
    reset = 1'b1; en64 = 1'b1; en8 = 1'b1;
    #0.1;
    checks++;
    if (q64 !== 64'h0 || qn64 !== ONES64) begin
      failures++;
      $display("FAIL reset_immediate q=%h qn=%h expected q=0 qn=%h", q64, qn64, ONES64);
    end
    checks++;
    if (q8 !== RV8 || qn8 !== ~RV8) begin
      failures++;
      $display("FAIL reset_value8 q=%h qn=%h expected q=%h qn=%h", q8, qn8, RV8, ~RV8);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (q64 !== 64'h0 || q8 !== RV8) begin
        failures++;
        $display("FAIL reset_held t=%0t q64=%h q8=%h expected 0 / %h", $realtime, q64, q8, RV8);
      end
    end
  endtask

  task automatic test_load();
    wait_until(200);
    reset = 1'b0;
    #1;
    checks++;
    if (q64 !== 64'h0 || q8 !== RV8) begin
      failures++;
      $display("FAIL post_reset_hold q64=%h q8=%h expected 0 / %h", q64, q8, RV8);
    end
    @(posedge clk); #1;
    checks++;
    if (q64 !== ONES64 || qn64 !== 64'h0 || q8 !== 8'hFF || qn8 !== 8'h00) begin
      failures++;
      $display("FAIL first_load q64=%h qn64=%h q8=%h qn8=%h expected %h 0 ff 00",
               q64, qn64, q8, qn8, ONES64);
    end
    // D and En wiggle between edges; Q must ignore them until the next rise.
    d64 = PAT1; d8 = 8'h3C; en64 = 1'b0; #1; en64 = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (q64 !== ONES64 || q8 !== 8'hFF) begin
      failures++;
      $display("FAIL between_edges q64=%h q8=%h expected %h ff", q64, q8, ONES64);
    end
    @(posedge clk); #1;
    checks++;
    if (q64 !== PAT1 || qn64 !== ~PAT1 || q8 !== 8'h3C) begin
      failures++;
      $display("FAIL second_load q64=%h qn64=%h q8=%h expected %h %h 3c", q64, qn64, q8, PAT1, ~PAT1);
    end
  endtask

  task automatic test_hold();
    d64 = A5; d8 = 8'hC3;
    @(posedge clk); #1;
    checks++;
    if (q64 !== A5 || q8 !== 8'hC3) begin
      failures++;
      $display("FAIL load_a5 q64=%h q8=%h expected %h c3", q64, q8, A5);
    end
    en64 = 1'b0; en8 = 1'b0; d64 = 64'h0; d8 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q64 !== A5 || qn64 !== ~A5 || q8 !== 8'hC3) begin
        failures++;
        $display("FAIL hold edge=%0d q64=%h q8=%h expected %h c3", i, q64, q8, A5);
      end
    end
  endtask

  task automatic test_reset_mid_cycle();
    en64 = 1'b1; en8 = 1'b1; d64 = ONES64; d8 = 8'hFF;
    @(posedge clk); #1;
    checks++;
    if (q64 !== ONES64) begin
      failures++;
      $display("FAIL mid_preload q64=%h expected %h", q64, ONES64);
    end
    en64 = 1'b0; en8 = 1'b0;
    #1 reset = 1'b1;
    #0.1;
    checks++;
    if (q64 !== 64'h0 || q8 !== RV8) begin
      failures++;
      $display("FAIL mid_pulse q64=%h q8=%h expected 0 / %h", q64, q8, RV8);
    end
    #1.9 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q64 !== 64'h0 || q8 !== RV8) begin
      failures++;
      $display("FAIL mid_after_pulse q64=%h q8=%h expected 0 / %h", q64, q8, RV8);
    end
    en64 = 1'b1; en8 = 1'b1; d64 = PAT2; d8 = 8'h81;
    @(posedge clk); #1;
    checks++;
    if (q64 !== PAT2 || q8 !== 8'h81) begin
      failures++;
      $display("FAIL mid_reload q64=%h q8=%h expected %h 81", q64, q8, PAT2);
    end
  endtask

  task automatic test_reset_at_edge();
    d64 = ONES64; d8 = 8'hFF; en64 = 1'b1; en8 = 1'b1;
    @(posedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (q64 !== 64'h0 || q8 !== RV8) begin
      failures++;
      $display("FAIL reset_at_edge q64=%h q8=%h expected 0 / %h", q64, q8, RV8);
    end
    @(negedge clk);
    reset = 1'b0; en64 = 1'b0; en8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q64 !== 64'h0 || q8 !== RV8) begin
      failures++;
      $display("FAIL reset_release_no_en q64=%h q8=%h expected 0 / %h", q64, q8, RV8);
    end
  endtask

  initial begin
    test_no_load();
    test_reset();
    test_load();
    test_hold();
    test_reset_mid_cycle();
    test_reset_at_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
